// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver with double-buffered digits, leading-zero suppression and blink.
// Latency: led/dp/an one cycle behind the scan index; frame_done is combinational. Backpressure: none, load always accepted.
module seg7_scan_driver #(
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] bcd_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  load,
    input  logic                  lz_en,
    input  logic [N_DIGITS-1:0]   blink_mask,
    output logic [6:0]            led,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_done
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(N_DIGITS);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(N_DIGITS - 1);
    localparam logic [FW-1:0] FCNT_MAX  = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0]         r_presc;
    logic [IW-1:0]         r_idx;
    logic [FW-1:0]         r_fcnt;
    logic                  r_phase;
    logic [4*N_DIGITS-1:0] r_act_bcd;
    logic [N_DIGITS-1:0]   r_act_dp;
    logic [4*N_DIGITS-1:0] r_pend_bcd;
    logic [N_DIGITS-1:0]   r_pend_dp;
    logic                  r_pend_vld;
    logic [6:0]            r_led;
    logic                  r_dp;
    logic [N_DIGITS-1:0]   r_an;

    logic                  w_tick;
    logic                  w_frame_end;
    logic [N_DIGITS-1:0]   w_zero_from;
    logic [3:0]            w_nib;
    logic                  w_dp_sel;
    logic                  w_blink_sel;
    logic                  w_zero_sel;
    logic                  w_suppress;
    logic                  w_blank;
    logic [6:0]            w_led_nxt;
    logic                  w_dp_nxt;
    logic [N_DIGITS-1:0]   w_an_nxt;

    function automatic logic [6:0] seg_code(input logic [3:0] v);
        case (v)
            4'd0:    seg_code = 7'b0000001;
            4'd1:    seg_code = 7'b1001111;
            4'd2:    seg_code = 7'b0010010;
            4'd3:    seg_code = 7'b0000110;
            4'd4:    seg_code = 7'b1001100;
            4'd5:    seg_code = 7'b0100100;
            4'd6:    seg_code = 7'b0100000;
            4'd7:    seg_code = 7'b0001111;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0000100;
            default: seg_code = 7'b1111110;
        endcase
    endfunction

    assign w_tick      = (r_presc == PRESC_MAX);
    assign w_frame_end = w_tick && (r_idx == IDX_MAX);
    assign frame_done  = w_frame_end && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_fcnt  <= '0;
            r_phase <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
            end
            if (w_frame_end) begin
                if (r_fcnt == FCNT_MAX) begin
                    r_fcnt  <= '0;
                    r_phase <= !r_phase;
                end else begin
                    r_fcnt <= r_fcnt + 1'b1;
                end
            end
        end
    end

    // A load on the frame-end edge wins over the valid clear, so it is shown one frame later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_act_bcd  <= '0;
            r_act_dp   <= '0;
            r_pend_bcd <= '0;
            r_pend_dp  <= '0;
            r_pend_vld <= 1'b0;
        end else begin
            if (w_frame_end && r_pend_vld) begin
                r_act_bcd  <= r_pend_bcd;
                r_act_dp   <= r_pend_dp;
                r_pend_vld <= 1'b0;
            end
            if (load) begin
                r_pend_bcd <= bcd_in;
                r_pend_dp  <= dp_in;
                r_pend_vld <= 1'b1;
            end
        end
    end

    // w_zero_from[k]: digit k and every digit above it are zero.
    always_comb begin
        logic v_zero;
        v_zero      = 1'b1;
        w_zero_from = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            v_zero         = v_zero && (r_act_bcd[4*k +: 4] == 4'd0);
            w_zero_from[k] = v_zero;
        end
    end

    always_comb begin
        w_nib       = 4'd0;
        w_dp_sel    = 1'b0;
        w_blink_sel = 1'b0;
        w_zero_sel  = 1'b0;
        w_an_nxt    = '1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (r_idx == IW'(k)) begin
                w_nib       = r_act_bcd[4*k +: 4];
                w_dp_sel    = r_act_dp[k];
                w_blink_sel = blink_mask[k];
                w_zero_sel  = w_zero_from[k];
                w_an_nxt[k] = 1'b0;
            end
        end
    end

    assign w_suppress = lz_en && (r_idx != '0) && w_zero_sel;
    assign w_blank    = r_phase && w_blink_sel;
    assign w_led_nxt  = (w_blank || w_suppress) ? 7'b1111111 : seg_code(w_nib);
    assign w_dp_nxt   = w_blank ? 1'b1 : !w_dp_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_led <= 7'b1111111;
            r_dp  <= 1'b1;
            r_an  <= '1;
        end else begin
            r_led <= w_led_nxt;
            r_dp  <= w_dp_nxt;
            r_an  <= w_an_nxt;
        end
    end

    assign led = r_led;
    assign dp  = r_dp;
    assign an  = r_an;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a cycle-level reference model feeding a scoreboard.
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        lz_en;
    logic [3:0]  blink_mask;
    logic [6:0]  led;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .N_DIGITS(ND),
        .SCAN_DIV(SD),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bcd_in(bcd_in),
        .dp_in(dp_in),
        .load(load),
        .lz_en(lz_en),
        .blink_mask(blink_mask),
        .led(led),
        .dp(dp),
        .an(an),
        .frame_done(frame_done)
    );

    typedef struct {
        logic [6:0] led;
        logic       dp;
        logic [3:0] an;
        logic       fd;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state; cyc counts edges since reset release.
    int          cyc = 0;
    logic [15:0] m_act_bcd = '0;
    logic [15:0] m_pend_bcd = '0;
    logic [3:0]  m_act_dp = '0;
    logic [3:0]  m_pend_dp = '0;
    logic        m_vld = 1'b0;
    logic        m_phase = 1'b0;
    int          m_fcnt = 0;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return 7'b1111110;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // One clock: predict outputs from pre-edge model state, advance model, then compare.
    task automatic step();
        exp_t e;
        exp_t ex;
        int d;
        logic fe, sup, blk;
        if (rst) begin
            e.led = 7'b1111111;
            e.dp  = 1'b1;
            e.an  = 4'b1111;
        end else begin
            d     = (cyc / SD) % ND;
            blk   = m_phase && blink_mask[d];
            sup   = lz_en && (d > 0) && ((m_act_bcd >> (4 * d)) == 16'h0);
            e.led = (blk || sup) ? 7'b1111111 : seg_of(m_act_bcd[4*d +: 4]);
            e.dp  = blk ? 1'b1 : ~m_act_dp[d];
            e.an  = ~(4'b0001 << d);
        end
        fe = !rst && (cyc % (SD * ND) == SD * ND - 1);
        if (rst) begin
            cyc = 0; m_act_bcd = '0; m_pend_bcd = '0; m_act_dp = '0; m_pend_dp = '0;
            m_vld = 1'b0; m_phase = 1'b0; m_fcnt = 0;
        end else begin
            if (fe && m_vld) begin
                m_act_bcd = m_pend_bcd;
                m_act_dp  = m_pend_dp;
                m_vld     = 1'b0;
            end
            if (fe) begin
                if (m_fcnt == BF - 1) begin
                    m_fcnt  = 0;
                    m_phase = !m_phase;
                end else begin
                    m_fcnt++;
                end
            end
            if (load) begin
                m_pend_bcd = bcd_in;
                m_pend_dp  = dp_in;
                m_vld      = 1'b1;
            end
            cyc++;
        end
        e.fd = !rst && (cyc % (SD * ND) == SD * ND - 1);
        sb.push_back(e);
        @(posedge clk);
        #1;
        ex = sb.pop_front();
        chk("sb_led", 32'(led), 32'(ex.led));
        chk("sb_dp", 32'(dp), 32'(ex.dp));
        chk("sb_an", 32'(an), 32'(ex.an));
        chk("sb_frame_done", 32'(frame_done), 32'(ex.fd));
    endtask

    // Advance to the next cycle whose frame position is p (bounded).
    task automatic run_to(input int p);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((cyc % (SD * ND)) != p && n < 40);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dv);
        bcd_in = v;
        dp_in  = dv;
        load   = 1'b1;
        step();
        load   = 1'b0;
    endtask

    initial begin
        logic [6:0] l [0:3];
        int fd_seen;
        rst = 1'b1; load = 1'b0; lz_en = 1'b0; blink_mask = 4'b0000;
        bcd_in = 16'h0; dp_in = 4'b0;

        repeat (3) step();
        chk("rst_led", 32'(led), 32'h7f);
        chk("rst_an", 32'(an), 32'hf);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_fd", 32'(frame_done), 32'h0);

        rst = 1'b0;
        step();
        chk("first_led", 32'(led), 32'(7'b0000001));
        chk("first_an", 32'(an), 32'(4'b1110));

        fd_seen = 0;
        repeat (32) begin
            step();
            if (frame_done) fd_seen++;
        end
        chk("fd_per_32_cycles", 32'(fd_seen), 32'd2);

        // Mid-frame load shows only after the next frame end
        run_to(5);
        do_load(16'h1234, 4'b0000);
        run_to(14);
        chk("load_hold_d3", 32'(led), 32'(7'b0000001));
        chk("load_hold_an", 32'(an), 32'(4'b0111));
        run_to(2);
        chk("load_d0_is_4", 32'(led), 32'(7'b1001100));
        run_to(14);
        chk("load_d3_is_1", 32'(led), 32'(7'b1001111));

        // Leading-zero suppression, dp kept on a suppressed digit
        lz_en = 1'b1;
        run_to(4);
        do_load(16'h0070, 4'b0100);
        run_to(15);
        run_to(2);
        chk("lz_d0", 32'(led), 32'(7'b0000001));
        run_to(6);
        chk("lz_d1", 32'(led), 32'(7'b0001111));
        run_to(10);
        chk("lz_d2_blank", 32'(led), 32'h7f);
        chk("lz_d2_dp_lit", 32'(dp), 32'h0);
        run_to(14);
        chk("lz_d3_blank", 32'(led), 32'h7f);
        do_load(16'h0000, 4'b0000);
        run_to(2);
        chk("lz_zero_d0", 32'(led), 32'(7'b0000001));
        run_to(6);
        chk("lz_zero_d1", 32'(led), 32'h7f);
        lz_en = 1'b0;

        // Loads coincident with frame_done
        run_to(15);
        chk("fd_at_end", 32'(frame_done), 32'h1);
        do_load(16'h5555, 4'b0000);
        run_to(2);
        chk("coinc_old_frame", 32'(led), 32'(7'b0000001));
        run_to(15);
        run_to(2);
        chk("coinc_5_d0", 32'(led), 32'(7'b0100100));
        run_to(14);
        chk("coinc_5_d3", 32'(led), 32'(7'b0100100));
        run_to(15);
        do_load(16'h9999, 4'b0000);
        run_to(2);
        chk("coinc_still_5", 32'(led), 32'(7'b0100100));
        run_to(15);
        run_to(2);
        chk("coinc_9_d0", 32'(led), 32'(7'b0000100));
        run_to(14);
        chk("coinc_9_d3", 32'(led), 32'(7'b0000100));

        // Blink on digit 0
        blink_mask = 4'b0001;
        do_load(16'h8888, 4'b0000);
        run_to(15);
        for (int f = 0; f < 4; f++) begin
            run_to(2);
            l[f] = led;
            run_to(6);
            chk("blink_d1_steady", 32'(led), 32'(7'b0000000));
        end
        chk("blink_phase_f0_f2", 32'(l[0] ^ l[2]), 32'h7f);
        chk("blink_phase_f1_f3", 32'(l[1] ^ l[3]), 32'h7f);
        blink_mask = 4'b0000;

        // Dash, then reset mid-frame discards pending
        do_load(16'h000A, 4'b0000);
        run_to(15);
        run_to(2);
        chk("dash_d0", 32'(led), 32'(7'b1111110));
        run_to(5);
        do_load(16'h1111, 4'b0000);
        run_to(7);
        rst = 1'b1;
        step();
        step();
        chk("midrst_led", 32'(led), 32'h7f);
        chk("midrst_an", 32'(an), 32'hf);
        chk("midrst_dp", 32'(dp), 32'h1);
        rst = 1'b0;
        step();
        chk("postrst_led", 32'(led), 32'(7'b0000001));
        chk("postrst_an", 32'(an), 32'(4'b1110));
        run_to(15);
        run_to(2);
        chk("pending_dropped_d0", 32'(led), 32'(7'b0000001));
        run_to(14);
        chk("pending_dropped_d3", 32'(led), 32'(7'b0000001));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
